// File: rtl/hdr_ddr_tx.sv
// rtl/hdr_ddr_tx.sv - HDR-DDR field serializer (preamble/byte/token/parity/CRC); macro HDR_TX_ERR_INJECT_EN adds parity error injection
module hdr_ddr_tx (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_sclgen_scl_pos_edge,
    input  logic       i_sclgen_scl_neg_edge,
    input  logic       i_ddrccc_tx_en,
    input  logic [3:0] i_ddrccc_tx_mode,
    input  logic [1:0] i_ddrccc_pre_value,
    input  logic [7:0] i_regf_tx_data,
    input  logic [4:0] i_crc_value,
    input  logic       i_crc_valid,
`ifdef HDR_TX_ERR_INJECT_EN
    input  logic       i_dbg_err_inject,
`endif
    output logic       o_sdahnd_tx_sda,
    output logic       o_ddrccc_tx_mode_done,
    output logic       o_crc_en,
    output logic       o_crc_data_valid,
    output logic [7:0] o_crc_data
);

    typedef enum logic [3:0] {
        MODE_PREAMBLE = 4'b0000,
        MODE_BYTE     = 4'b0011,
        MODE_TOKEN    = 4'b0101,
        MODE_PARITY   = 4'b0110,
        MODE_CRC      = 4'b0111,
        MODE_IDLE     = 4'b1111
    } mode_e;

    localparam logic [3:0] TOKEN_BITS = 4'hC;

    mode_e       cur_mode;
    mode_e       mode_q, mode_d;
    logic [2:0]  cnt_q, cnt_d, cnt_cur;
    logic [7:0]  byte_q, byte_d;
    logic [4:0]  crc_q, crc_d;
    logic        byte_sel_q, byte_sel_d;
    logic [15:0] word_q, word_d;
    logic        sda_q, sda_d;
    logic        done_q, done_d;
    logic        crc_en_q, crc_en_d;
    logic        crc_dv_q, crc_dv_d;
    logic [7:0]  crc_data_q, crc_data_d;
    logic        scl_edge;
    logic        par_p1, par_p0;
    logic        inj_sel;
    logic        launch, last_bit, tx_bit;

`ifdef HDR_TX_ERR_INJECT_EN
    logic inj_q, inj_d;
`endif

    assign scl_edge = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;

    // Parity over the two-byte word: P1 covers odd bits, P0 even bits inverted.
    assign par_p1 = ^(word_q & 16'hAAAA);
    assign par_p0 = ~^(word_q & 16'h5555);

    // Decode the requested field; disabled or unknown codes collapse to idle.
    always_comb begin
        cur_mode = MODE_IDLE;
        if (i_ddrccc_tx_en) begin
            case (i_ddrccc_tx_mode)
                4'b0000: cur_mode = MODE_PREAMBLE;
                4'b0011: cur_mode = MODE_BYTE;
                4'b0101: cur_mode = MODE_TOKEN;
                4'b0110: cur_mode = MODE_PARITY;
                4'b0111: cur_mode = MODE_CRC;
                default: cur_mode = MODE_IDLE;
            endcase
        end
    end

    // A mode change aborts the running field, so the bit index restarts at 0.
    assign cnt_cur = (cur_mode != mode_q) ? 3'd0 : cnt_q;

`ifdef HDR_TX_ERR_INJECT_EN
    // Injection request is taken on the first parity bit and held for the second.
    always_comb begin
        inj_d   = inj_q;
        inj_sel = inj_q;
        if (cur_mode == MODE_PARITY && cnt_cur == 3'd0) begin
            inj_sel = i_dbg_err_inject;
            if (scl_edge) begin
                inj_d = i_dbg_err_inject;
            end
        end
    end
`else
    assign inj_sel = 1'b0;
`endif

    // Per-edge bit selection, counter advance and end-of-field bookkeeping.
    always_comb begin
        mode_d     = cur_mode;
        cnt_d      = cnt_cur;
        byte_d     = byte_q;
        crc_d      = crc_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        sda_d      = sda_q;
        done_d     = 1'b0;
        crc_dv_d   = 1'b0;
        crc_data_d = crc_data_q;
        crc_en_d   = (cur_mode == MODE_BYTE) || (cur_mode == MODE_CRC);
        launch     = 1'b0;
        last_bit   = 1'b0;
        tx_bit     = 1'b1;

        case (cur_mode)
            MODE_PREAMBLE: begin
                launch   = scl_edge;
                tx_bit   = (cnt_cur == 3'd0) ? i_ddrccc_pre_value[1] : i_ddrccc_pre_value[0];
                last_bit = (cnt_cur == 3'd1);
                if (scl_edge && last_bit) begin
                    byte_sel_d = 1'b0;
                end
            end
            MODE_BYTE: begin
                launch   = scl_edge;
                last_bit = (cnt_cur == 3'd7);
                if (cnt_cur == 3'd0) begin
                    tx_bit = i_regf_tx_data[7];
                    if (scl_edge) begin
                        byte_d = i_regf_tx_data;
                    end
                end else begin
                    tx_bit = byte_q[3'd7 - cnt_cur];
                end
                if (scl_edge && last_bit) begin
                    crc_dv_d   = 1'b1;
                    crc_data_d = byte_q;
                    byte_sel_d = ~byte_sel_q;
                    if (byte_sel_q) begin
                        word_d[7:0] = byte_q;
                    end else begin
                        word_d[15:8] = byte_q;
                    end
                end
            end
            MODE_TOKEN: begin
                launch   = scl_edge;
                tx_bit   = TOKEN_BITS[2'd3 - cnt_cur[1:0]];
                last_bit = (cnt_cur == 3'd3);
            end
            MODE_PARITY: begin
                launch   = scl_edge;
                tx_bit   = ((cnt_cur == 3'd0) ? par_p1 : par_p0) ^ inj_sel;
                last_bit = (cnt_cur == 3'd1);
            end
            MODE_CRC: begin
                last_bit = (cnt_cur == 3'd4);
                if (cnt_cur == 3'd0) begin
                    // Until a valid CRC has been latched, edges only hold SDA high.
                    tx_bit = i_crc_value[4];
                    if (scl_edge) begin
                        if (i_crc_valid) begin
                            launch = 1'b1;
                            crc_d  = i_crc_value;
                        end else begin
                            sda_d = 1'b1;
                        end
                    end
                end else begin
                    launch = scl_edge;
                    tx_bit = crc_q[3'd4 - cnt_cur];
                end
            end
            default: begin
                sda_d = 1'b1;
                cnt_d = 3'd0;
            end
        endcase

        if (launch) begin
            sda_d = tx_bit;
            if (last_bit) begin
                cnt_d  = 3'd0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_cur + 3'd1;
            end
        end
    end

    // State and registered outputs; reset discards any field in flight.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            mode_q     <= MODE_IDLE;
            cnt_q      <= 3'd0;
            byte_q     <= 8'd0;
            crc_q      <= 5'd0;
            byte_sel_q <= 1'b0;
            word_q     <= 16'd0;
            sda_q      <= 1'b1;
            done_q     <= 1'b0;
            crc_en_q   <= 1'b0;
            crc_dv_q   <= 1'b0;
            crc_data_q <= 8'd0;
        end else begin
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            crc_q      <= crc_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            sda_q      <= sda_d;
            done_q     <= done_d;
            crc_en_q   <= crc_en_d;
            crc_dv_q   <= crc_dv_d;
            crc_data_q <= crc_data_d;
        end
    end

`ifdef HDR_TX_ERR_INJECT_EN
    // Latched injection request for the parity field.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`endif

    assign o_sdahnd_tx_sda       = sda_q;
    assign o_ddrccc_tx_mode_done = done_q;
    assign o_crc_en              = crc_en_q;
    assign o_crc_data_valid      = crc_dv_q;
    assign o_crc_data            = crc_data_q;

endmodule

// File: tb/tb_hdr_ddr_tx.sv
// tb/tb_hdr_ddr_tx.sv - self-checking bench for hdr_ddr_tx (vector table, hand sequences, randomized model)
module tb_hdr_ddr_tx;

    localparam logic [3:0] M_PRE  = 4'b0000;
    localparam logic [3:0] M_BYTE = 4'b0011;
    localparam logic [3:0] M_TOK  = 4'b0101;
    localparam logic [3:0] M_PAR  = 4'b0110;
    localparam logic [3:0] M_CRC  = 4'b0111;
    localparam logic [3:0] M_IDLE = 4'b1111;

    logic       clk = 1'b0;
    logic       rst;
    logic       pos_e, neg_e, en;
    logic [3:0] mode;
    logic [1:0] pre;
    logic [7:0] data;
    logic [4:0] crc_val;
    logic       crc_valid;
    logic       sda, done, crc_en, cv;
    logic [7:0] cd;
`ifdef HDR_TX_ERR_INJECT_EN
    logic       inj;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] mode;
        logic [1:0] pre;
        logic [7:0] data;
        logic       cv_in;
        logic [4:0] crc_in;
        logic       e_sda;
        logic       e_done;
        logic       e_cv;
        logic [7:0] e_cd;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    hdr_ddr_tx dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst),
        .i_sclgen_scl_pos_edge (pos_e),
        .i_sclgen_scl_neg_edge (neg_e),
        .i_ddrccc_tx_en        (en),
        .i_ddrccc_tx_mode      (mode),
        .i_ddrccc_pre_value    (pre),
        .i_regf_tx_data        (data),
        .i_crc_value           (crc_val),
        .i_crc_valid           (crc_valid),
`ifdef HDR_TX_ERR_INJECT_EN
        .i_dbg_err_inject      (inj),
`endif
        .o_sdahnd_tx_sda       (sda),
        .o_ddrccc_tx_mode_done (done),
        .o_crc_en              (crc_en),
        .o_crc_data_valid      (cv),
        .o_crc_data            (cd)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] m, input logic [1:0] p, input logic [7:0] d,
                       input logic vin, input logic [4:0] cin, input logic es,
                       input logic ed, input logic ecv, input logic [7:0] ecd);
        vec_t v;
        v.mode = m; v.pre = p; v.data = d; v.cv_in = vin; v.crc_in = cin;
        v.e_sda = es; v.e_done = ed; v.e_cv = ecv; v.e_cd = ecd;
        tbl.push_back(v);
    endtask

    // One SCL edge strobe (random polarity); returns on the negedge after it.
    task automatic edge_cycle();
        if ($urandom_range(0, 1) == 1) pos_e = 1'b1;
        else                           neg_e = 1'b1;
        @(negedge clk);
        pos_e = 1'b0;
        neg_e = 1'b0;
    endtask

    task automatic edge_check(input logic e_sda, input logic e_done, input logic e_cv,
                              input logic [7:0] e_cd, input logic e_en, input int gaps);
        edge_cycle();
        chk("sda", 8'(sda), 8'(e_sda));
        chk("mode_done", 8'(done), 8'(e_done));
        chk("crc_data_valid", 8'(cv), 8'(e_cv));
        if (e_cv) chk("crc_data", cd, e_cd);
        chk("crc_en", 8'(crc_en), 8'(e_en));
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            chk("done_gap", 8'(done), 8'd0);
            chk("crc_valid_gap", 8'(cv), 8'd0);
            chk("sda_hold", 8'(sda), 8'(e_sda));
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        mode = M_IDLE;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        mode = M_BYTE;
        for (int b = 7; b >= 0; b--) begin
            data = (b == 7) ? d : 8'($urandom);
            edge_check(d[b], b == 0, b == 0, d, 1'b1, 1);
        end
    endtask

    // Randomized fields checked against a field-level model of the serializer.
    task automatic rand_fields(input int n);
        logic [7:0] hi, lo, d;
        logic       sel;
        logic [1:0] p;
        logic [4:0] c;
        logic [15:0] w;
        logic       p1, p0;
        int         kind, waits, gaps;
        logic       eq[$];
        logic       last;
        hi = 8'd0; lo = 8'd0; sel = 1'b0; d = 8'd0; p = 2'd0; c = 5'd0;
        for (int f = 0; f < n; f++) begin
            kind  = $urandom_range(0, 4);
            waits = 0;
            eq.delete();
            case (kind)
                0: begin
                    p = 2'($urandom); mode = M_PRE; pre = p;
                    eq.push_back(p[1]); eq.push_back(p[0]);
                end
                1: begin
                    d = 8'($urandom); mode = M_BYTE;
                    for (int i = 7; i >= 0; i--) eq.push_back(d[i]);
                end
                2: begin
                    mode = M_TOK;
                    eq.push_back(1'b1); eq.push_back(1'b1); eq.push_back(1'b0); eq.push_back(1'b0);
                end
                3: begin
                    mode = M_PAR;
                    w  = {hi, lo};
                    p1 = 1'b0;
                    p0 = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        if (i % 2 == 1) p1 = p1 ^ w[i];
                        else            p0 = p0 ^ w[i];
                    end
                    eq.push_back(p1); eq.push_back(p0);
                end
                default: begin
                    mode  = M_CRC;
                    c     = 5'($urandom);
                    waits = $urandom_range(0, 3);
                    for (int i = 4; i >= 0; i--) eq.push_back(c[i]);
                end
            endcase
            for (int k = 0; k < waits; k++) begin
                crc_valid = 1'b0;
                crc_val   = 5'($urandom);
                edge_check(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, $urandom_range(0, 2));
            end
            for (int k = 0; k < eq.size(); k++) begin
                last = (k == eq.size() - 1);
                gaps = $urandom_range(0, 2);
                if (kind == 1) data = (k == 0) ? d : 8'($urandom);
                if (kind == 4) begin
                    crc_valid = (k == 0) ? 1'b1 : 1'($urandom);
                    crc_val   = (k == 0) ? c : 5'($urandom);
                end
                edge_check(eq[k], last, (kind == 1) && last, d, (kind == 1) || (kind == 4), gaps);
            end
            if (kind == 0) sel = 1'b0;
            if (kind == 1) begin
                if (sel) lo = d;
                else     hi = d;
                sel = ~sel;
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) en = 1'b0;
                else                           mode = 4'h8 + 4'($urandom_range(0, 7));
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk("idle_sda", 8'(sda), 8'd1);
                    chk("idle_done", 8'(done), 8'd0);
                end
                en = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq_a5, seq_3c;
        logic [3:0] seq_tok;
        logic [4:0] seq_crc;

        rst = 1'b1; pos_e = 1'b0; neg_e = 1'b0; en = 1'b1; mode = M_IDLE;
        pre = 2'b00; data = 8'h00; crc_val = 5'd0; crc_valid = 1'b0;
`ifdef HDR_TX_ERR_INJECT_EN
        inj = 1'b0;
`endif
        // Vector table: preamble, two bytes, parity, token, CRC with wait.
        seq_a5  = 8'b1010_0101;
        seq_3c  = 8'b0011_1100;
        seq_tok = 4'b1100;
        seq_crc = 5'b10011;
        add(M_PRE, 2'b01, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(M_PRE, 2'b01, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int b = 0; b < 8; b++)
            add(M_BYTE, 2'b00, 8'hA5, 1'b0, 5'd0, seq_a5[7 - b], b == 7, b == 7, 8'hA5);
        for (int b = 0; b < 8; b++)
            add(M_BYTE, 2'b00, 8'h3C, 1'b0, 5'd0, seq_3c[7 - b], b == 7, b == 7, 8'h3C);
        add(M_PAR, 2'b00, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        add(M_PAR, 2'b00, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int b = 0; b < 4; b++)
            add(M_TOK, 2'b00, 8'h00, 1'b0, 5'd0, seq_tok[3 - b], b == 3, 1'b0, 8'h00);
        for (int b = 0; b < 3; b++)
            add(M_CRC, 2'b00, 8'h00, 1'b0, 5'h0A, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 5; b++)
            add(M_CRC, 2'b00, 8'h00, 1'b1, 5'h13, seq_crc[4 - b], b == 4, 1'b0, 8'h00);

        // Reset values while reset is held.
        @(negedge clk);
        @(negedge clk);
        chk("rst_sda", 8'(sda), 8'd1);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_crc_en", 8'(crc_en), 8'd0);
        chk("rst_crc_valid", 8'(cv), 8'd0);
        chk("rst_crc_data", cd, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            mode      = tbl[i].mode;
            pre       = tbl[i].pre;
            data      = tbl[i].data;
            crc_valid = tbl[i].cv_in;
            crc_val   = tbl[i].crc_in;
            edge_check(tbl[i].e_sda, tbl[i].e_done, tbl[i].e_cv, tbl[i].e_cd,
                       (tbl[i].mode == M_BYTE) || (tbl[i].mode == M_CRC), 1);
        end

        // Reset in the middle of a byte, then a fresh byte.
        mode = M_BYTE;
        data = 8'hA5;
        for (int b = 7; b >= 4; b--) edge_check(seq_a5[b], 1'b0, 1'b0, 8'h00, 1'b1, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_sda", 8'(sda), 8'd1);
        chk("async_rst_done", 8'(done), 8'd0);
        chk("async_rst_crc_en", 8'(crc_en), 8'd0);
        mode = M_IDLE;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_done", 8'(done), 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sda", 8'(sda), 8'd1);
        send_byte(8'hFF);

        // Mode change mid-byte aborts it; the token starts at bit 0 on the same edge.
        mode = M_BYTE;
        data = 8'h00;
        for (int b = 0; b < 3; b++) edge_check(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1);
        mode = M_TOK;
        for (int b = 0; b < 4; b++) edge_check(seq_tok[3 - b], b == 3, 1'b0, 8'h00, 1'b0, 1);

        // Disabled block and unknown mode codes only idle the line.
        en   = 1'b0;
        mode = M_BYTE;
        data = 8'h00;
        for (int b = 0; b < 3; b++) edge_check(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1);
        en   = 1'b1;
        mode = 4'b0001;
        for (int b = 0; b < 2; b++) edge_check(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1);

`ifdef HDR_TX_ERR_INJECT_EN
        // Injection inverts both parity bits of one field only.
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h3C);
        mode = M_PAR;
        inj  = 1'b1;
        edge_check(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1);
        inj  = 1'b0;
        edge_check(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1);
        edge_check(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1);
        edge_check(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1);
`endif

        // Randomized fields from a clean reset state.
        do_reset();
        rand_fields(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
